// File: rtl/cache_ctrl_assoc_pkg.sv
// Shared types and address helpers for the set-associative read-only cache controller.
// Default-geometry field widths live here; modules derive their own from their parameters.
package cache_pkg;

   localparam int ADDR_W_DEF     = 32;
   localparam int WORD_W_DEF     = 32;
   localparam int LINE_WORDS_DEF = 2;
   localparam int SETS_DEF       = 4;
   localparam int WAYS_DEF       = 2;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOOKUP    = 3'd1,
      S_MISS_REQ  = 3'd2,
      S_MISS_WAIT = 3'd3,
      S_FILL      = 3'd4
   } cache_state_e;

   // Ceiling log2 with log2c(1) == 0, usable in constant expressions.
   function automatic int log2c(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   localparam int OFF_W  = log2c(WORD_W_DEF / 8);
   localparam int WSEL_W = log2c(LINE_WORDS_DEF);
   localparam int IDX_W  = log2c(SETS_DEF);
   localparam int AGE_W  = log2c(WAYS_DEF);
   localparam int TAG_W  = ADDR_W_DEF - OFF_W - WSEL_W - IDX_W;

   // Extract 'width' bits starting at 'lsb'; a zero-width field reads as 0.
   function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb,
                                              input int width);
      logic [63:0] mask;
      mask = (width == 0) ? 64'd0 : ((64'd1 << width) - 64'd1);
      return (addr >> lsb) & mask;
   endfunction

   function automatic logic [63:0] line_mask(input int lsb);
      return ~((64'd1 << lsb) - 64'd1);
   endfunction

endpackage

// File: rtl/cache_ctrl_assoc_if.sv
// CPU load port and memory line-fill bus of the cache controller, bundled with
// a slave view (the controller) and a master view (CPU plus memory model).
interface cache_ctrl_assoc_if #(
   parameter int ADDR_W     = 32,
   parameter int WORD_W     = 32,
   parameter int LINE_WORDS = 2
);
   // A transfer happens on a rising edge where valid and ready are both high;
   // once raised, valid and its payload stay stable until that edge.
   // resp_valid and mem_rvalid are single-cycle pulses with no backpressure.
   logic                         req_valid;
   logic                         req_ready;
   logic [ADDR_W-1:0]            req_addr;
   logic                         resp_valid;
   logic [WORD_W-1:0]            resp_data;
   logic                         inv;
   logic                         mem_arvalid;
   logic                         mem_arready;
   logic [ADDR_W-1:0]            mem_araddr;
   logic                         mem_rvalid;
   logic [WORD_W*LINE_WORDS-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_addr, inv, mem_arready, mem_rvalid, mem_rdata,
      output req_ready, resp_valid, resp_data, mem_arvalid, mem_araddr
   );

   modport master (
      output req_valid, req_addr, inv, mem_arready, mem_rvalid, mem_rdata,
      input  req_ready, resp_valid, resp_data, mem_arvalid, mem_araddr
   );
endinterface

// File: rtl/cache_lru_set.sv
// True-LRU bookkeeping for one set: age update for an accessed way and victim choice
// (lowest invalid way first, otherwise the way whose age is WAYS-1).
module cache_lru_set #(
   parameter int WAYS  = 2,
   parameter int AGE_W = 1
) (
   input  logic [WAYS-1:0][AGE_W-1:0] ages_in,
   input  logic [WAYS-1:0]            valid_in,
   input  logic [AGE_W-1:0]           acc_way,
   output logic [WAYS-1:0][AGE_W-1:0] ages_out,
   output logic [AGE_W-1:0]           victim
);

   if (WAYS == 1) begin : g_direct
      logic unused_in;
      assign unused_in = ^{ages_in, valid_in, acc_way};
      assign ages_out  = '0;
      assign victim    = '0;
   end else begin : g_lru
      always_comb begin
         logic found;
         victim = '0;
         found  = 1'b0;
         for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_in[w]) begin
               victim = AGE_W'(w);
               found  = 1'b1;
            end
         end
         if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
               if (ages_in[w] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
            end
         end
      end

      // Younger-than-accessed ways age by one; the accessed way becomes MRU.
      always_comb begin
         ages_out = ages_in;
         for (int w = 0; w < WAYS; w++) begin
            if (w == int'(acc_way)) ages_out[w] = '0;
            else if (ages_in[w] < ages_in[acc_way]) ages_out[w] = ages_in[w] + AGE_W'(1);
         end
      end
   end

endmodule

// File: rtl/cache_ctrl_assoc.sv
// Parametrised read-only set-associative cache controller with a miss FSM and invalidate.
// Build option CACHE_STATS_EN adds saturating hit/miss counters on hit_cnt/miss_cnt.
module cache_ctrl_assoc
   import cache_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int WORD_W     = 32,
   parameter int LINE_WORDS = 2,
   parameter int SETS       = 4,
   parameter int WAYS       = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   cache_ctrl_assoc_if.slave    bus,
`ifdef CACHE_STATS_EN
   output logic [31:0]          hit_cnt,
   output logic [31:0]          miss_cnt,
`endif
   output cache_state_e         dbg_state
);

   localparam int OFF_BITS  = log2c(WORD_W / 8);
   localparam int WSEL_BITS = log2c(LINE_WORDS);
   localparam int IDX_BITS  = log2c(SETS);
   localparam int AGE_BITS  = log2c(WAYS);
   localparam int TAG_BITS  = ADDR_W - OFF_BITS - WSEL_BITS - IDX_BITS;
   localparam int WSEL_S    = (WSEL_BITS > 0) ? WSEL_BITS : 1;
   localparam int IDX_S     = (IDX_BITS > 0) ? IDX_BITS : 1;
   localparam int AGE_S     = (AGE_BITS > 0) ? AGE_BITS : 1;
   localparam int LINE_W    = WORD_W * LINE_WORDS;

   cache_state_e                    state_q, state_d;
   logic [ADDR_W-1:0]               addr_q;
   logic [LINE_W-1:0]               fill_q;
   logic                            resp_valid_q;
   logic [WORD_W-1:0]               resp_data_q;
   logic [SETS-1:0][WAYS-1:0]       valid_q;
   logic [SETS-1:0][WAYS-1:0][AGE_S-1:0] age_q;
   logic [TAG_BITS-1:0]             tag_mem  [SETS][WAYS];
   logic [LINE_W-1:0]               data_mem [SETS][WAYS];

   logic [IDX_S-1:0]                idx;
   logic [WSEL_S-1:0]               wsel;
   logic [TAG_BITS-1:0]             tag;
   logic                            hit;
   logic [AGE_S-1:0]                hit_way, victim, acc_way;
   logic [WAYS-1:0][AGE_S-1:0]      ages_out;
   logic                            req_ready_c, arvalid_c;

   assign idx  = IDX_S'(addr_field(64'(addr_q), OFF_BITS + WSEL_BITS, IDX_BITS));
   assign wsel = WSEL_S'(addr_field(64'(addr_q), OFF_BITS, WSEL_BITS));
   assign tag  = TAG_BITS'(addr_field(64'(addr_q), OFF_BITS + WSEL_BITS + IDX_BITS, TAG_BITS));

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[idx][w] && (tag_mem[idx][w] == tag)) begin
            hit     = 1'b1;
            hit_way = AGE_S'(w);
         end
      end
   end

   // The victim never depends on acc_way, so this mux closes no loop.
   assign acc_way = (state_q == S_FILL) ? victim : hit_way;

   cache_lru_set #(.WAYS(WAYS), .AGE_W(AGE_S)) u_lru (
      .ages_in  (age_q[idx]),
      .valid_in (valid_q[idx]),
      .acc_way  (acc_way),
      .ages_out (ages_out),
      .victim   (victim)
   );

   always_comb begin
      state_d     = state_q;
      req_ready_c = 1'b0;
      arvalid_c   = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready_c = !bus.inv;
            if (!bus.inv && bus.req_valid) state_d = S_LOOKUP;
         end
         S_LOOKUP:    state_d = hit ? S_IDLE : S_MISS_REQ;
         S_MISS_REQ: begin
            arvalid_c = 1'b1;
            if (bus.mem_arready) state_d = S_MISS_WAIT;
         end
         S_MISS_WAIT: if (bus.mem_rvalid) state_d = S_FILL;
         S_FILL:      state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         fill_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         valid_q      <= '0;
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_S'(w);
      end else begin
         state_q      <= state_d;
         resp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.inv) begin
                  valid_q <= '0;
                  for (int s = 0; s < SETS; s++)
                     for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_S'(w);
               end else if (bus.req_valid) begin
                  addr_q <= bus.req_addr;
               end
            end
            S_LOOKUP: begin
               if (hit) begin
                  resp_valid_q <= 1'b1;
                  resp_data_q  <= data_mem[idx][hit_way][int'(wsel) * WORD_W +: WORD_W];
                  age_q[idx]   <= ages_out;
               end
            end
            S_MISS_WAIT: if (bus.mem_rvalid) fill_q <= bus.mem_rdata;
            S_FILL: begin
               valid_q[idx][victim] <= 1'b1;
               age_q[idx]           <= ages_out;
               resp_valid_q         <= 1'b1;
               resp_data_q          <= fill_q[int'(wsel) * WORD_W +: WORD_W];
            end
            default: ;
         endcase
      end
   end

   // Tag/data arrays carry no reset; the valid bits gate every use.
   always_ff @(posedge clk) begin
      if (!rst && state_q == S_FILL) begin
         tag_mem[idx][victim]  <= tag;
         data_mem[idx][victim] <= fill_q;
      end
   end

`ifdef CACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (state_q == S_LOOKUP) begin
         if (hit) hit_cnt <= (&hit_cnt) ? hit_cnt : hit_cnt + 32'd1;
         else     miss_cnt <= (&miss_cnt) ? miss_cnt : miss_cnt + 32'd1;
      end
   end
`endif

   assign bus.req_ready   = req_ready_c;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_data   = resp_data_q;
   assign bus.mem_arvalid = arvalid_c;
   assign bus.mem_araddr  = addr_q & ADDR_W'(line_mask(OFF_BITS + WSEL_BITS));
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Directed bench for cache_ctrl_assoc: default 4-set/2-way/2-word instance plus an
// 8-set/4-way/4-word instance; CACHE_STATS_EN also checks the hit/miss counters.
module tb_cache_ctrl_assoc;
   import cache_pkg::*;

   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   cache_ctrl_assoc_if #(.ADDR_W(32), .WORD_W(32), .LINE_WORDS(2)) bus ();
   cache_ctrl_assoc_if #(.ADDR_W(32), .WORD_W(32), .LINE_WORDS(4)) bbus ();
   cache_state_e dbg_state, bdbg_state;
`ifdef CACHE_STATS_EN
   logic [31:0] hit_cnt, miss_cnt, bhit_cnt, bmiss_cnt;
`endif

   cache_ctrl_assoc #(.ADDR_W(32), .WORD_W(32), .LINE_WORDS(2), .SETS(4), .WAYS(2)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
`ifdef CACHE_STATS_EN
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt),
`endif
      .dbg_state (dbg_state)
   );

   cache_ctrl_assoc #(.ADDR_W(32), .WORD_W(32), .LINE_WORDS(4), .SETS(8), .WAYS(4)) u_big (
      .clk       (clk),
      .rst       (rst),
      .bus       (bbus),
`ifdef CACHE_STATS_EN
      .hit_cnt   (bhit_cnt),
      .miss_cnt  (bmiss_cnt),
`endif
      .dbg_state (bdbg_state)
   );

   int          n_vec = 0;
   int          n_bad = 0;
   bit          stall_bad;
   logic [31:0] last_araddr;
   int          b_hs = 0;

   logic [31:0] lru_addr [7];
   logic [31:0] lru_data [7];
   bit          lru_miss [7];
   logic [31:0] big_addr [8];
   bit          big_miss [8];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory image of the default instance: line 0x10 is special, others encode their address.
   function automatic logic [63:0] line_of(input logic [31:0] line_addr);
      if (line_addr == 32'h10) return {32'hBBBB_BBBB, 32'hAAAA_AAAA};
      return {32'hD000_0000 | (line_addr + 32'd4), 32'hD000_0000 | line_addr};
   endfunction

   function automatic logic [127:0] big_line_of(input logic [31:0] line_addr);
      logic [127:0] l;
      for (int i = 0; i < 4; i++) l[i*32 +: 32] = 32'hE000_0000 | (line_addr + 32'(4 * i));
      return l;
   endfunction

   // Default-instance read: CPU driver plus memory responder with arready stall and reply delay.
   task automatic rd(input logic [31:0] addr, input int stall, input int delay, input bit spurious,
                     output logic [31:0] data, output int lat, output bit missed, output bit ok);
      int phase, waitn;
      bit accepted;
      ok = 1'b0; lat = 0; data = '0; phase = 0; waitn = 0; accepted = 1'b0; stall_bad = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      for (int i = 0; i < 20 && !accepted; i++) begin
         accepted = bus.req_ready;
         @(negedge clk);
      end
      bus.req_valid = 1'b0;
      for (int c = 1; c < 300 && !ok; c++) begin
         bus.mem_rvalid  = 1'b0;
         bus.mem_arready = 1'b0;
         if (bus.resp_valid) begin
            data = bus.resp_data;
            lat  = c;
            ok   = 1'b1;
         end else begin
            if (phase == 0 && bus.mem_arvalid) begin
               last_araddr = bus.mem_araddr;
               phase = 1;
               waitn = 0;
            end
            if (phase == 1) begin
               if (bus.mem_arvalid !== 1'b1 || bus.mem_araddr !== last_araddr || bus.req_ready !== 1'b0)
                  stall_bad = 1'b1;
               if (waitn < stall) begin
                  if (spurious) begin
                     bus.mem_rvalid = 1'b1;
                     bus.mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
                  end
                  waitn++;
               end else begin
                  bus.mem_arready = 1'b1;
                  phase = 2;
                  waitn = 0;
               end
            end else if (phase == 2) begin
               if (bus.mem_arvalid !== 1'b0) stall_bad = 1'b1;
               if (waitn >= delay) begin
                  bus.mem_rvalid = 1'b1;
                  bus.mem_rdata  = line_of(last_araddr);
                  phase = 3;
               end
               waitn++;
            end
            @(negedge clk);
         end
      end
      missed = (phase != 0);
   endtask

   task automatic do_vec(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                         input bit exp_miss, input int stall, input int delay, input bit spurious);
      logic [31:0] data;
      int lat;
      bit missed, ok;
      rd(addr, stall, delay, spurious, data, lat, missed, ok);
      check({tag, "_done"}, 64'(ok), 64'(1));
      check({tag, "_data"}, 64'(data), 64'(exp_data));
      check({tag, "_miss"}, 64'(missed), 64'(exp_miss));
      if (exp_miss) check({tag, "_araddr"}, 64'(last_araddr), 64'(addr & 32'hFFFF_FFF8));
      else          check({tag, "_lat"}, 64'(lat), 64'(2));
   endtask

   // Large-geometry memory: always ready, replies two cycles after the address handshake.
   initial begin
      int pend;
      logic [31:0] pa;
      pend = 0; pa = '0;
      bbus.mem_arready = 1'b1;
      bbus.mem_rvalid  = 1'b0;
      bbus.mem_rdata   = '0;
      forever begin
         @(negedge clk);
         bbus.mem_rvalid = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               bbus.mem_rvalid = 1'b1;
               bbus.mem_rdata  = big_line_of(pa);
            end
         end else if (bbus.mem_arvalid) begin
            pa   = bbus.mem_araddr;
            pend = 2;
            b_hs++;
         end
      end
   end

   task automatic brd(input logic [31:0] addr, output logic [31:0] data, output bit ok);
      bit accepted;
      ok = 1'b0; data = '0; accepted = 1'b0;
      @(negedge clk);
      bbus.req_valid = 1'b1;
      bbus.req_addr  = addr;
      for (int i = 0; i < 20 && !accepted; i++) begin
         accepted = bbus.req_ready;
         @(negedge clk);
      end
      bbus.req_valid = 1'b0;
      for (int c = 0; c < 300 && !ok; c++) begin
         if (bbus.resp_valid) begin
            data = bbus.resp_data;
            ok   = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
   endtask

   initial begin
      logic [31:0] data, a;
      bit ok, seen, got_resp;
      int hs0, base_hs;

      lru_addr = '{32'h00, 32'h20, 32'h00, 32'h40, 32'h00, 32'h20, 32'h04};
      lru_data = '{32'hD000_0000, 32'hD000_0020, 32'hD000_0000, 32'hD000_0040,
                   32'hD000_0000, 32'hD000_0020, 32'hD000_0004};
      lru_miss = '{1, 1, 0, 1, 0, 1, 0};
      big_addr = '{32'h000, 32'h080, 32'h100, 32'h180, 32'h000, 32'h200, 32'h000, 32'h080};
      big_miss = '{1, 1, 1, 1, 0, 1, 0, 1};

      bus.req_valid = 1'b0; bus.req_addr = '0; bus.inv = 1'b0;
      bus.mem_arready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      bbus.req_valid = 1'b0; bbus.req_addr = '0; bbus.inv = 1'b0;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_req_ready", 64'(bus.req_ready), 64'(1));
      check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
      check("rst_resp_data", 64'(bus.resp_data), 64'(0));
      check("rst_arvalid", 64'(bus.mem_arvalid), 64'(0));
      check("rst_araddr", 64'(bus.mem_araddr), 64'(0));
      check("rst_state", 64'(dbg_state), 64'(S_IDLE));

      do_vec("cold_0x10", 32'h10, 32'hAAAA_AAAA, 1'b1, 0, 3, 1'b0);
      do_vec("hit_0x14", 32'h14, 32'hBBBB_BBBB, 1'b0, 0, 0, 1'b0);

      for (int i = 0; i < 7; i++)
         do_vec($sformatf("lru%0d", i), lru_addr[i], lru_data[i], lru_miss[i], 0, 1, 1'b0);

      do_vec("stall_0x08", 32'h08, 32'hD000_0008, 1'b1, 5, 2, 1'b1);
      check("stall_stable", 64'(stall_bad), 64'(0));

      @(negedge clk);
      bus.inv = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'h00;
      #1 check("inv_req_ready", 64'(bus.req_ready), 64'(0));
      @(negedge clk);
      bus.inv = 1'b0; bus.req_valid = 1'b0;
      check("inv_state", 64'(dbg_state), 64'(S_IDLE));
      got_resp = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.resp_valid) got_resp = 1'b1;
      end
      check("inv_no_resp", 64'(got_resp), 64'(0));
      do_vec("inv_0x00", 32'h00, 32'hD000_0000, 1'b1, 0, 0, 1'b0);

      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_addr = 32'h28;
      @(negedge clk);
      bus.req_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (bus.mem_arvalid) seen = 1'b1;
         else @(negedge clk);
      end
      check("rmm_arvalid", 64'(seen), 64'(1));
      bus.mem_arready = 1'b1;
      @(negedge clk);
      bus.mem_arready = 1'b0;
      check("rmm_wait_state", 64'(dbg_state), 64'(S_MISS_WAIT));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rmm_arvalid_low", 64'(bus.mem_arvalid), 64'(0));
      check("rmm_req_ready", 64'(bus.req_ready), 64'(1));
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h1111_1111_2222_2222;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      check("rmm_no_resp", 64'(bus.resp_valid), 64'(0));
      do_vec("rmm_0x00", 32'h00, 32'hD000_0000, 1'b1, 0, 0, 1'b0);
      do_vec("rmm_0x28", 32'h28, 32'hD000_0028, 1'b1, 0, 0, 1'b0);
      do_vec("rmm_0x04", 32'h04, 32'hD000_0004, 1'b0, 0, 0, 1'b0);
`ifdef CACHE_STATS_EN
      check("stats_hit", 64'(hit_cnt), 64'(1));
      check("stats_miss", 64'(miss_cnt), 64'(2));
`endif

      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      base_hs = b_hs;
      for (int i = 0; i < 8; i++) begin
         hs0 = b_hs;
         brd(big_addr[i], data, ok);
         check($sformatf("big%0d_done", i), 64'(ok), 64'(1));
         check($sformatf("big%0d_data", i), 64'(data), 64'(32'hE000_0000 | big_addr[i]));
         check($sformatf("big%0d_miss", i), 64'(b_hs - hs0), 64'(big_miss[i]));
      end
      for (int i = 0; i < 40; i++) begin
         a = (32'($urandom_range(0, 5)) << 7) | (32'($urandom_range(0, 3)) << 4) |
             (32'($urandom_range(0, 3)) << 2);
         brd(a, data, ok);
         check($sformatf("rnd%0d_data", i), 64'(data), 64'(32'hE000_0000 | a));
      end
`ifdef CACHE_STATS_EN
      check("big_stats_total", 64'(bhit_cnt + bmiss_cnt), 64'(48));
      check("big_stats_miss", 64'(bmiss_cnt), 64'(b_hs - base_hs));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/cache_ctrl_assoc.md
Name: cache_ctrl_assoc

Overview:
- Parametrised read-only set-associative cache controller; successor to the fixed 4-set, 2-way, 2-word-line cache.
- Sits between the CPU load port and main memory.
- Serves hits from the tag/data arrays; on a miss, issues one line-fill request to memory, allocates a way (invalid first, else true-LRU), then returns the requested word.
- Adds over the previous generation: configurable geometry, valid/ready request handshake, an explicit miss FSM and a whole-cache invalidate.

Parameters:
- ADDR_W, 32, byte address width.
- WORD_W, 32, CPU data width (multiple of 8).
- LINE_WORDS, 2, words per line; power of 2, >=1.
- SETS, 4, number of sets; power of 2, >=1.
- WAYS, 2, associativity; power of 2, >=1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU read request.
- req_ready  out  1  controller can accept a request.
- req_addr  in  ADDR_W  byte address.
- resp_valid  out  1  one-cycle pulse: resp_data is valid.
- resp_data  out  WORD_W  returned word.
- inv  in  1  invalidate all lines; honoured only in IDLE.
- mem_arvalid  out  1  line-fill request.
- mem_arready  in  1  memory accepts the request.
- mem_araddr  out  ADDR_W  line-aligned address (offset and word-select bits zero).
- mem_rvalid  in  1  fill data valid.
- mem_rdata  in  WORD_W*LINE_WORDS  full line; word 0 in LSBs.

Behaviour:
- Address split, LSB first:
  - byte offset log2(WORD_W/8) bits, ignored;
  - word select log2(LINE_WORDS) bits;
  - index log2(SETS) bits;
  - tag = remaining bits.
- Per entry: valid, tag, line data. Per set: WAYS age counters of log2(WAYS) bits each; age 0 = MRU, WAYS-1 = LRU.
- Reset:
  - all valid bits cleared; age[w] = w in every set;
  - req_ready=1, resp_valid=0, resp_data=0, mem_arvalid=0, mem_araddr=0;
  - FSM to IDLE.
  - Reset mid-miss abandons the miss: mem_arvalid drops next cycle, any later mem_rvalid is ignored.
- FSM states: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL.
- IDLE:
  - req_ready=1.
  - req_valid&req_ready: latch address -> LOOKUP.
  - inv without req_valid: clear all valid bits and re-initialise ages, stay IDLE.
  - inv with req_valid in the same cycle: inv takes priority; the request is not accepted (req_ready=0 that cycle).
- LOOKUP (req_ready=0):
  - Compare all ways.
  - Hit: next cycle resp_valid=1 with the selected word; update ages; -> IDLE.
  - Hit latency = 2 cycles after acceptance.
  - Miss: -> MISS_REQ.
- MISS_REQ:
  - mem_arvalid=1, mem_araddr=line address, both held stable until mem_arready.
  - Handshake cycle -> MISS_WAIT; mem_arvalid=0 next cycle.
- MISS_WAIT:
  - Wait any number of cycles for mem_rvalid; on mem_rvalid -> FILL.
  - mem_rvalid in any other state is ignored.
- FILL:
  - Victim = lowest-index invalid way; else the way with age WAYS-1.
  - Write tag, data, valid=1; update ages.
  - resp_valid=1 with word from mem_rdata (bypass, not a re-read of the array); -> IDLE.
- Age update on hit or fill of way k with old age a: ages < a increment, age[k]=0, others unchanged. Ages remain a permutation of 0..WAYS-1.
- Only one outstanding request at a time; no response backpressure.
- WAYS=1 degenerates to direct-mapped (age logic removed).

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - adds output ports hit_cnt[31:0] and miss_cnt[31:0];
  - both reset to 0, incremented in LOOKUP on hit/miss, saturating at all-ones;
  - inv does not clear them.
- Undefined: ports and counters absent; functional behaviour identical.

Decomposition:
- Package cache_pkg:
  - localparams derived from the parameters: OFF_W, WSEL_W, IDX_W, TAG_W, AGE_W;
  - FSM state enum;
  - address-field extraction functions.
- One sub-module: cache_lru_set, which takes the current ages and the accessed way and returns the updated ages plus the victim way. Instantiated once, operating on the indexed set.

Test Plan:
- Cold miss: reset; read 0x0000_0010; memory replies after 3 cycles with line {0xBBBB_BBBB,0xAAAA_AAAA} -> mem_araddr=0x10, resp_data=0xAAAA_AAAA; then read 0x14 -> hit, resp_data=0xBBBB_BBBB 2 cycles after acceptance, no mem_arvalid.
- LRU eviction (default geometry): fill 0x00, 0x20 (same set 0); read 0x00 again; read 0x40 -> way holding 0x20 is evicted; 0x00 still hits, 0x20 misses.
- Handshake stall: hold mem_arready=0 for 5 cycles -> mem_arvalid and mem_araddr stay stable, req_ready=0 throughout; spurious mem_rvalid during MISS_REQ is ignored.
- Invalidate: fill 0x00; pulse inv with req_valid=1 -> request not accepted; re-read 0x00 -> miss.
- Reset mid-miss: assert rst during MISS_WAIT -> mem_arvalid=0, req_ready=1 after reset; subsequent mem_rvalid writes nothing (0x00 still misses).
- Geometry sweep: WAYS=4, SETS=8, LINE_WORDS=4 random reads against a reference model -> all resp_data match; with CACHE_STATS_EN, hit_cnt+miss_cnt equals number of requests.
